// File: rtl/fetch_unit.sv
// fetch_unit: ARMv4 instruction fetch stage, PC + imem req/rvalid fetch into IR, valid/ready hand-off to decode
// Ports: clk/reset (sync, active-high); imem_req/imem_addr/imem_rvalid/imem_rdata (imem side);
//        instr_valid/instr_ready/instr/instr_pc/pc_plus8 (decode side); flush/br_target (execute redirect);
//        fetch_cnt (instructions accepted by decode), fetch_err (sticky imem timeout)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8,
    input  logic        flush,
    input  logic [31:0] br_target,
    output logic [31:0] fetch_cnt,
    output logic        fetch_err
);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic {FETCH, HOLD} state_t;
    state_t state;
    logic [31:0] pc;
    logic [TW-1:0] timer;
    assign imem_req    = state == FETCH;
    assign instr_valid = state == HOLD;
    assign imem_addr   = pc;
    assign pc_plus8    = instr_pc + 32'd8;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            instr     <= '0;
            instr_pc  <= '0;
            fetch_cnt <= '0;
            fetch_err <= 1'b0;
            timer     <= '0;
        end else if (flush) begin
            // squash whatever is in flight: a response or a decode hand-off this cycle is wrong-path
            pc    <= {br_target[31:2], 2'b00};
            state <= FETCH;
            timer <= '0;
        end else if (state == FETCH) begin
            if (imem_rvalid) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
                pc       <= pc + 32'd4;
                timer    <= '0;
                state    <= HOLD;
            end else if (timer == TW'(TIMEOUT - 1)) begin
                // flag the stall but keep requesting
                fetch_err <= 1'b1;
                timer     <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end else if (instr_ready) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= FETCH;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a cycle-level behavioural model and per-cycle compare
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int TIMEOUT = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic imem_req, imem_rvalid, instr_valid, fetch_err;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc_plus8, fetch_cnt;
    logic instr_ready = 1'b1;
    logic flush = 1'b0;
    logic [31:0] br_target = '0;
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int mem_lat = 0;
    bit mem_en = 1'b1;
    int mem_cnt = 0;
    bit m_fetch;
    logic [31:0] m_pc, m_ir, m_ipc, m_cnt;
    bit m_err;
    int m_wait;

    fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .pc_plus8(pc_plus8), .flush(flush), .br_target(br_target),
        .fetch_cnt(fetch_cnt), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // memory: answers after mem_lat cycles of continuous request, data is the inverted address
    assign imem_rvalid = mem_en && imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata  = ~imem_addr;
    always @(posedge clk) mem_cnt <= (imem_req && !imem_rvalid && !flush && !reset) ? mem_cnt + 1 : 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_fetch = 1; m_pc = RESET_PC; m_ir = 0; m_ipc = 0; m_cnt = 0; m_err = 0; m_wait = 0;
        end else if (flush) begin
            m_pc = {br_target[31:2], 2'b00}; m_fetch = 1; m_wait = 0;
        end else if (m_fetch) begin
            if (imem_rvalid) begin
                m_ir = ~m_pc; m_ipc = m_pc; m_pc = m_pc + 4; m_fetch = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_err = 1; m_wait = 0;
                end
            end
        end else if (instr_ready) begin
            m_cnt = m_cnt + 1; m_fetch = 1;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("req", {31'd0, imem_req}, {31'd0, m_fetch});
        if (m_fetch) chk("addr", imem_addr, m_pc);
        chk("valid", {31'd0, instr_valid}, {31'd0, !m_fetch});
        chk("instr", instr, m_ir);
        chk("instr_pc", instr_pc, m_ipc);
        chk("pc_plus8", pc_plus8, m_ipc + 32'd8);
        chk("cnt", fetch_cnt, m_cnt);
        chk("err", {31'd0, fetch_err}, {31'd0, m_err});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        reset = 1'b0;
        // zero-wait memory, decode always ready
        cyc(6);
        chk("t1_cnt", fetch_cnt, 32'd3);
        chk("t1_addr", imem_addr, 32'd12);
        chk("t1_ipc", instr_pc, 32'd8);
        chk("t1_ir", instr, 32'hFFFF_FFF7);
        // slow memory, decode stalls
        mem_lat = 3;
        instr_ready = 1'b0;
        cyc(4);
        chk("t2_valid", {31'd0, instr_valid}, 32'd1);
        cyc(5);
        chk("t2_ipc", instr_pc, 32'd12);
        chk("t2_cnt", fetch_cnt, 32'd3);
        instr_ready = 1'b1;
        cyc(1);
        chk("t2_cnt1", fetch_cnt, 32'd4);
        // flush in HOLD with a hand-off in the same cycle
        mem_lat = 0;
        instr_ready = 1'b0;
        cyc(1);
        instr_ready = 1'b1;
        flush = 1'b1;
        br_target = 32'h0000_0103;
        cyc(1);
        flush = 1'b0;
        chk("t3_addr", imem_addr, 32'h0000_0100);
        chk("t3_valid", {31'd0, instr_valid}, 32'd0);
        chk("t3_cnt", fetch_cnt, 32'd4);
        // flush coincident with a response
        flush = 1'b1;
        br_target = 32'h0000_0200;
        cyc(1);
        flush = 1'b0;
        chk("t4_ipc", instr_pc, 32'd16);
        chk("t4_addr", imem_addr, 32'h0000_0200);
        // memory never answers
        mem_en = 1'b0;
        cyc(15);
        chk("t5_err0", {31'd0, fetch_err}, 32'd0);
        cyc(1);
        chk("t5_err1", {31'd0, fetch_err}, 32'd1);
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        mem_en = 1'b1;
        instr_ready = 1'b0;
        cyc(1);
        chk("t5_valid", {31'd0, instr_valid}, 32'd1);
        chk("t5_ipc", instr_pc, 32'h0000_0200);
        chk("t5_err", {31'd0, fetch_err}, 32'd1);
        // PC wrap at the top of the address space
        instr_ready = 1'b1;
        flush = 1'b1;
        br_target = 32'hFFFF_FFFE;
        cyc(1);
        flush = 1'b0;
        instr_ready = 1'b0;
        cyc(1);
        chk("t6_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("t6_p8", pc_plus8, 32'h0000_0004);
        instr_ready = 1'b1;
        cyc(1);
        chk("t6_addr0", imem_addr, 32'h0000_0000);
        // reset while a fetch is waiting
        mem_lat = 5;
        cyc(1);
        flush = 1'b1;
        br_target = 32'h0000_0040;
        cyc(1);
        flush = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_rst_addr", imem_addr, RESET_PC);
        chk("t6_rst_err", {31'd0, fetch_err}, 32'd0);
        chk("t6_rst_cnt", fetch_cnt, 32'd0);
        mem_lat = 0;
        cyc(4);
        chk("t6_cnt2", fetch_cnt, 32'd2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
